// File: rtl/iperm_dat_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | iperm_dat_fifo                                                           |
// | Elastic req/ack token FIFO feeding the iperm control join data port.     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module iperm_dat_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             t_dat_req,
   output logic             t_dat_ack,
   input  logic [WIDTH-1:0] t_dat_data,
   output logic             i_dat_req,
   input  logic             i_dat_ack,
   output logic [WIDTH-1:0] i_dat_data,
   input  logic             flush,
   output logic [CNT_W-1:0] level
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] c_full_lvl = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_level;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;

   assign w_full  = (r_level == c_full_lvl);
   assign w_empty = (r_level == '0);

   // Handshake outputs depend only on registered state (plus flush/reset gating),
   // so nothing on the t_dat side reaches the i_dat side combinationally.
   assign t_dat_ack  = reset_n & ~w_full & ~flush;
   assign i_dat_req  = ~w_empty;
   assign i_dat_data = w_empty ? '0 : r_mem[r_rd_ptr];
   assign level      = r_level;

   assign w_push = t_dat_req & t_dat_ack;
   assign w_pop  = i_dat_req & i_dat_ack & ~flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_level <= r_level - CNT_W'(1);
         end
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= t_dat_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_iperm_dat_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_iperm_dat_fifo                                                        |
// | Self-checking bench: directed scenarios on DEPTH=4, random on 2 and 8.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_iperm_dat_fifo;

   localparam int W      = 32;
   localparam int NTOK   = 10000;
   localparam int MAXCYC = 80000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n = 1'b0;

   logic          a_req = 0, a_ack = 0, a_flush = 0, a_tack, a_ireq;
   logic [W-1:0]  a_wdata = '0, a_rdata;
   logic [2:0]    a_level;

   logic          b_req = 0, b_ack = 0, b_flush = 0, b_tack, b_ireq;
   logic [W-1:0]  b_wdata = '0, b_rdata;
   logic [1:0]    b_level;

   logic          c_req = 0, c_ack = 0, c_flush = 0, c_tack, c_ireq;
   logic [W-1:0]  c_wdata = '0, c_rdata;
   logic [3:0]    c_level;

   int n_vec = 0;
   int n_err = 0;

   iperm_dat_fifo #(.WIDTH(W), .DEPTH(4)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .t_dat_req(a_req), .t_dat_ack(a_tack), .t_dat_data(a_wdata),
      .i_dat_req(a_ireq), .i_dat_ack(a_ack), .i_dat_data(a_rdata),
      .flush(a_flush), .level(a_level));

   iperm_dat_fifo #(.WIDTH(W), .DEPTH(2)) u_dut_d2 (
      .clk(clk), .reset_n(reset_n),
      .t_dat_req(b_req), .t_dat_ack(b_tack), .t_dat_data(b_wdata),
      .i_dat_req(b_ireq), .i_dat_ack(b_ack), .i_dat_data(b_rdata),
      .flush(b_flush), .level(b_level));

   iperm_dat_fifo #(.WIDTH(W), .DEPTH(8)) u_dut_d8 (
      .clk(clk), .reset_n(reset_n),
      .t_dat_req(c_req), .t_dat_ack(c_tack), .t_dat_data(c_wdata),
      .i_dat_req(c_ireq), .i_dat_ack(c_ack), .i_dat_data(c_rdata),
      .flush(c_flush), .level(c_level));

   // Occupancy bound watch on every instance
   always @(negedge clk) begin
      n_vec = n_vec + 3;
      if (a_level > 3'd4) begin
         n_err++; $display("FAIL level_bound_d4 actual=%0d required<=4", a_level);
      end
      if (b_level > 2'd2) begin
         n_err++; $display("FAIL level_bound_d2 actual=%0d required<=2", b_level);
      end
      if (c_level > 4'd8) begin
         n_err++; $display("FAIL level_bound_d8 actual=%0d required<=8", c_level);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_vec += 4;
      if (a_tack !== 1'b0) begin n_err++; $display("FAIL rst_tack actual=%b required=0", a_tack); end
      if (a_ireq !== 1'b0) begin n_err++; $display("FAIL rst_ireq actual=%b required=0", a_ireq); end
      if (a_rdata !== '0)  begin n_err++; $display("FAIL rst_data actual=%h required=0", a_rdata); end
      if (a_level !== 3'd0) begin n_err++; $display("FAIL rst_level actual=%0d required=0", a_level); end
      @(negedge clk) reset_n = 1'b1;
      step();
      n_vec += 2;
      if (a_tack !== 1'b1) begin n_err++; $display("FAIL post_rst_tack actual=%b required=1", a_tack); end
      if (a_level !== 3'd0) begin n_err++; $display("FAIL post_rst_level actual=%0d required=0", a_level); end
      // fill to three then reset mid-stream
      a_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_wdata = 32'hD0 + i;
         step();
      end
      a_req = 1'b0;
      n_vec++;
      if (a_level !== 3'd3) begin n_err++; $display("FAIL midrst_pre_level actual=%0d required=3", a_level); end
      #1 reset_n = 1'b0;
      #1;
      n_vec += 4;
      if (a_tack !== 1'b0) begin n_err++; $display("FAIL midrst_tack actual=%b required=0", a_tack); end
      if (a_ireq !== 1'b0) begin n_err++; $display("FAIL midrst_ireq actual=%b required=0", a_ireq); end
      if (a_rdata !== '0)  begin n_err++; $display("FAIL midrst_data actual=%h required=0", a_rdata); end
      if (a_level !== 3'd0) begin n_err++; $display("FAIL midrst_level actual=%0d required=0", a_level); end
      @(negedge clk) reset_n = 1'b1;
      step();
      n_vec += 3;
      if (a_tack !== 1'b1) begin n_err++; $display("FAIL midrst_rel_tack actual=%b required=1", a_tack); end
      if (a_level !== 3'd0) begin n_err++; $display("FAIL midrst_rel_level actual=%0d required=0", a_level); end
      if (a_ireq !== 1'b0) begin n_err++; $display("FAIL midrst_rel_ireq actual=%b required=0", a_ireq); end
   endtask

   task automatic test_fill();
      a_ack = 1'b0;
      a_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a_wdata = 32'hA0 + k;
         step();
         n_vec += 3;
         if (int'(a_level) !== k + 1) begin n_err++; $display("FAIL fill_level k=%0d actual=%0d required=%0d", k, a_level, k + 1); end
         if (a_rdata !== 32'hA0) begin n_err++; $display("FAIL fill_head k=%0d actual=%h required=a0", k, a_rdata); end
         if (a_ireq !== 1'b1) begin n_err++; $display("FAIL fill_ireq k=%0d actual=%b required=1", k, a_ireq); end
      end
      n_vec++;
      if (a_tack !== 1'b0) begin n_err++; $display("FAIL fill_full_tack actual=%b required=0", a_tack); end
      a_wdata = 32'hEE;
      step();
      n_vec += 2;
      if (a_level !== 3'd4) begin n_err++; $display("FAIL full_hold_level actual=%0d required=4", a_level); end
      if (a_rdata !== 32'hA0) begin n_err++; $display("FAIL full_hold_head actual=%h required=a0", a_rdata); end
      a_req = 1'b0;
   endtask

   task automatic test_drain();
      a_ack = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_vec += 2;
         if (a_ireq !== 1'b1) begin n_err++; $display("FAIL drain_ireq k=%0d actual=%b required=1", k, a_ireq); end
         if (a_rdata !== 32'hA0 + k) begin n_err++; $display("FAIL drain_data k=%0d actual=%h required=%h", k, a_rdata, 32'hA0 + k); end
         step();
      end
      n_vec += 3;
      if (a_ireq !== 1'b0) begin n_err++; $display("FAIL drain_end_ireq actual=%b required=0", a_ireq); end
      if (a_level !== 3'd0) begin n_err++; $display("FAIL drain_end_level actual=%0d required=0", a_level); end
      if (a_rdata !== '0) begin n_err++; $display("FAIL drain_end_data actual=%h required=0", a_rdata); end
      a_ack = 1'b0;
   endtask

   task automatic test_back_to_back();
      a_req = 1'b1;
      for (int k = 0; k < 2; k++) begin
         a_wdata = 32'hB0 + k;
         step();
      end
      a_ack = 1'b1;
      for (int k = 0; k < 10; k++) begin
         a_wdata = 32'hB2 + k;
         n_vec += 3;
         if (a_level !== 3'd2) begin n_err++; $display("FAIL b2b_level k=%0d actual=%0d required=2", k, a_level); end
         if (a_rdata !== 32'hB0 + k) begin n_err++; $display("FAIL b2b_data k=%0d actual=%h required=%h", k, a_rdata, 32'hB0 + k); end
         if (a_tack !== 1'b1) begin n_err++; $display("FAIL b2b_tack k=%0d actual=%b required=1", k, a_tack); end
         step();
      end
      a_req = 1'b0;
      for (int k = 10; k < 12; k++) begin
         n_vec++;
         if (a_rdata !== 32'hB0 + k) begin n_err++; $display("FAIL b2b_tail k=%0d actual=%h required=%h", k, a_rdata, 32'hB0 + k); end
         step();
      end
      a_ack = 1'b0;
      n_vec++;
      if (a_level !== 3'd0) begin n_err++; $display("FAIL b2b_end_level actual=%0d required=0", a_level); end
   endtask

   task automatic test_flush();
      a_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         a_wdata = 32'hC0 + k;
         step();
      end
      a_wdata = 32'hC3;
      a_flush = 1'b1;
      #1;
      n_vec += 2;
      if (a_tack !== 1'b0) begin n_err++; $display("FAIL flush_tack actual=%b required=0", a_tack); end
      if (a_level !== 3'd3) begin n_err++; $display("FAIL flush_pre_level actual=%0d required=3", a_level); end
      step();
      a_flush = 1'b0;
      #1;
      n_vec += 3;
      if (a_level !== 3'd0) begin n_err++; $display("FAIL flush_level actual=%0d required=0", a_level); end
      if (a_ireq !== 1'b0) begin n_err++; $display("FAIL flush_ireq actual=%b required=0", a_ireq); end
      if (a_tack !== 1'b1) begin n_err++; $display("FAIL flush_after_tack actual=%b required=1", a_tack); end
      step();
      a_req = 1'b0;
      n_vec += 2;
      if (a_level !== 3'd1) begin n_err++; $display("FAIL flush_held_level actual=%0d required=1", a_level); end
      if (a_rdata !== 32'hC3) begin n_err++; $display("FAIL flush_held_data actual=%h required=c3", a_rdata); end
      a_ack = 1'b1;
      step();
      a_ack = 1'b0;
   endtask

   task automatic test_random();
      logic [W-1:0] qb[$];
      logic [W-1:0] qc[$];
      int sent_b = 0, recv_b = 0, sent_c = 0, recv_c = 0;
      int cyc = 0;
      bit push_b, pop_b, push_c, pop_c;
      while ((recv_b < NTOK || recv_c < NTOK) && cyc < MAXCYC) begin
         n_vec += 8;
         if (int'(b_level) !== qb.size()) begin n_err++; $display("FAIL rnd_d2_level cyc=%0d actual=%0d required=%0d", cyc, b_level, qb.size()); end
         if (b_ireq !== (qb.size() != 0)) begin n_err++; $display("FAIL rnd_d2_ireq cyc=%0d actual=%b required=%b", cyc, b_ireq, qb.size() != 0); end
         if (b_tack !== (qb.size() != 2)) begin n_err++; $display("FAIL rnd_d2_tack cyc=%0d actual=%b required=%b", cyc, b_tack, qb.size() != 2); end
         if (b_rdata !== ((qb.size() != 0) ? qb[0] : '0)) begin n_err++; $display("FAIL rnd_d2_data cyc=%0d actual=%h required=%h", cyc, b_rdata, (qb.size() != 0) ? qb[0] : '0); end
         if (int'(c_level) !== qc.size()) begin n_err++; $display("FAIL rnd_d8_level cyc=%0d actual=%0d required=%0d", cyc, c_level, qc.size()); end
         if (c_ireq !== (qc.size() != 0)) begin n_err++; $display("FAIL rnd_d8_ireq cyc=%0d actual=%b required=%b", cyc, c_ireq, qc.size() != 0); end
         if (c_tack !== (qc.size() != 8)) begin n_err++; $display("FAIL rnd_d8_tack cyc=%0d actual=%b required=%b", cyc, c_tack, qc.size() != 8); end
         if (c_rdata !== ((qc.size() != 0) ? qc[0] : '0)) begin n_err++; $display("FAIL rnd_d8_data cyc=%0d actual=%h required=%h", cyc, c_rdata, (qc.size() != 0) ? qc[0] : '0); end

         b_req   = (sent_b < NTOK) && ($urandom_range(0, 3) != 0);
         b_wdata = $urandom;
         b_ack   = ($urandom_range(0, 2) != 0);
         c_req   = (sent_c < NTOK) && ($urandom_range(0, 2) != 0);
         c_wdata = $urandom;
         c_ack   = ($urandom_range(0, 3) != 0);
         push_b = b_req && (qb.size() < 2);
         pop_b  = b_ack && (qb.size() > 0);
         push_c = c_req && (qc.size() < 8);
         pop_c  = c_ack && (qc.size() > 0);
         step();
         cyc++;
         if (pop_b)  begin void'(qb.pop_front()); recv_b++; end
         if (push_b) begin qb.push_back(b_wdata); sent_b++; end
         if (pop_c)  begin void'(qc.pop_front()); recv_c++; end
         if (push_c) begin qc.push_back(c_wdata); sent_c++; end
      end
      b_req = 0; b_ack = 0; c_req = 0; c_ack = 0;
      n_vec++;
      if (recv_b < NTOK || recv_c < NTOK) begin
         n_err++;
         $display("FAIL rnd_timeout recv_d2=%0d recv_d8=%0d required=%0d", recv_b, recv_c, NTOK);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_back_to_back();
      test_flush();
      test_random();
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
